// File: rtl/census_pkg.sv
// Shared constants and FSM encoding for the census disparity pipeline.
package census_pkg;

    localparam int CENSUS_NUM_DISP   = 64;
    localparam int CENSUS_COST_WIDTH = 7;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } census_state_t;

endpackage

// File: rtl/census_min_update.sv
// Combinational compare-and-select for the running best (and, optionally, second-best) cost.
// Second-best tracking is present only when CENSUS_WTA_UNIQUENESS_EN is defined.
module census_min_update #(
    parameter int COST_WIDTH = 7,
    parameter int DISP_WIDTH = 6
) (
    input  logic                  first,
    input  logic [COST_WIDTH-1:0] cost,
    input  logic [DISP_WIDTH-1:0] idx,
    input  logic [COST_WIDTH-1:0] best_cost,
    input  logic [DISP_WIDTH-1:0] best_idx,
`ifdef CENSUS_WTA_UNIQUENESS_EN
    input  logic [COST_WIDTH-1:0] second,
    output logic [COST_WIDTH-1:0] upd_second,
`endif
    output logic [COST_WIDTH-1:0] upd_cost,
    output logic [DISP_WIDTH-1:0] upd_idx
);

    // Strict less-than keeps the lowest disparity on ties.
    always_comb begin
        upd_cost = best_cost;
        upd_idx  = best_idx;
        if (first || (cost < best_cost)) begin
            upd_cost = cost;
            upd_idx  = idx;
        end
    end

`ifdef CENSUS_WTA_UNIQUENESS_EN
    // All-ones stands in for "no second yet"; it is also the correct value if every later cost is all-ones.
    always_comb begin
        upd_second = second;
        if (first)
            upd_second = '1;
        else if (cost < best_cost)
            upd_second = best_cost;
        else if (cost < second)
            upd_second = cost;
    end
`endif

endmodule

// File: rtl/census_wta.sv
// Winner-take-all over NUM_DISP streamed census costs per pixel, with registered result handshake.
// Optional uniqueness check enabled by defining CENSUS_WTA_UNIQUENESS_EN.
module census_wta
    import census_pkg::*;
#(
    parameter int NUM_DISP    = CENSUS_NUM_DISP,
    parameter int COST_WIDTH  = CENSUS_COST_WIDTH,
    parameter int UNIQ_MARGIN = 2,
    localparam int DISP_WIDTH = $clog2(NUM_DISP)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  cost_valid,
    input  logic [COST_WIDTH-1:0] cost,
    output logic                  cost_ready,
    output logic                  disp_valid,
    output logic [DISP_WIDTH-1:0] disp,
    output logic [COST_WIDTH-1:0] min_cost,
    output logic                  disp_ambig,
    input  logic                  disp_ready
);

    census_state_t         state, state_nxt;
    logic [DISP_WIDTH-1:0] cnt;
    logic [COST_WIDTH-1:0] best_cost, upd_cost;
    logic [DISP_WIDTH-1:0] best_idx, upd_idx;
    logic                  accept, last_beat, ambig_nxt;

    assign cost_ready = (state == ACCUM);
    assign accept     = en && cost_valid && cost_ready;
    assign last_beat  = (cnt == DISP_WIDTH'(NUM_DISP - 1));

`ifdef CENSUS_WTA_UNIQUENESS_EN
    localparam logic [COST_WIDTH:0] MARGIN = (COST_WIDTH + 1)'(UNIQ_MARGIN);
    logic [COST_WIDTH-1:0] second, upd_second, gap;
    logic                  ambig_q;

    assign gap        = upd_second - upd_cost;
    assign ambig_nxt  = (NUM_DISP < 2) || ({1'b0, gap} < MARGIN);
    assign disp_ambig = ambig_q;
`else
    assign ambig_nxt  = 1'b0;
    assign disp_ambig = 1'b0;
`endif

    census_min_update #(
        .COST_WIDTH (COST_WIDTH),
        .DISP_WIDTH (DISP_WIDTH)
    ) u_min_update (
        .first      (cnt == '0),
        .cost       (cost),
        .idx        (cnt),
        .best_cost  (best_cost),
        .best_idx   (best_idx),
`ifdef CENSUS_WTA_UNIQUENESS_EN
        .second     (second),
        .upd_second (upd_second),
`endif
        .upd_cost   (upd_cost),
        .upd_idx    (upd_idx)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && last_beat) state_nxt = HOLD;
            HOLD:    if (en && disp_valid && disp_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ACCUM;
        else
            state <= state_nxt;
    end

    // NOTE: the running best needs no reset: beat 0 always overwrites it before it is ever read.
    always_ff @(posedge clk) begin
        if (accept) begin
            best_cost <= upd_cost;
            best_idx  <= upd_idx;
`ifdef CENSUS_WTA_UNIQUENESS_EN
            second    <= upd_second;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            disp_valid <= 1'b0;
            disp       <= '0;
            min_cost   <= '0;
`ifdef CENSUS_WTA_UNIQUENESS_EN
            ambig_q    <= 1'b0;
`endif
        end else if (en) begin
            if (accept) begin
                cnt <= last_beat ? '0 : cnt + 1'b1;
                if (last_beat) begin
                    disp_valid <= 1'b1;
                    disp       <= upd_idx;
                    min_cost   <= upd_cost;
`ifdef CENSUS_WTA_UNIQUENESS_EN
                    ambig_q    <= ambig_nxt;
`endif
                end
            end else if (disp_valid && disp_ready) begin
                disp_valid <= 1'b0;
            end
        end
    end

`ifndef CENSUS_WTA_UNIQUENESS_EN
    logic unused_ambig;
    assign unused_ambig = ambig_nxt;
`endif

endmodule

// File: tb/tb_census_wta.sv
// Directed self-checking bench for census_wta with NUM_DISP=4, COST_WIDTH=7.
module tb_census_wta;

    localparam int ND = 4;
    localparam int CW = 7;
    localparam int DW = 2;
`ifdef CENSUS_WTA_UNIQUENESS_EN
    localparam bit UNIQ = 1'b1;
`else
    localparam bit UNIQ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, en, cost_valid, disp_ready;
    logic [CW-1:0] cost;
    logic          cost_ready, disp_valid, disp_ambig;
    logic [DW-1:0] disp;
    logic [CW-1:0] min_cost;

    int checks = 0;
    int errors = 0;

    census_wta #(.NUM_DISP(ND), .COST_WIDTH(CW), .UNIQ_MARGIN(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cost_valid (cost_valid),
        .cost       (cost),
        .cost_ready (cost_ready),
        .disp_valid (disp_valid),
        .disp       (disp),
        .min_cost   (min_cost),
        .disp_ambig (disp_ambig),
        .disp_ready (disp_ready)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic stream4(input logic [CW-1:0] a, b, c, d);
        logic [CW-1:0] v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 4; i++) begin
            cost_valid = 1'b1;
            cost       = v[i];
            tick();
        end
        cost_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; cost_valid = 1'b0; cost = '0; disp_ready = 1'b0;
        tick(); tick();
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", disp_valid); end
        checks++; if (cost_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cost_ready); end
        checks++; if ({disp, min_cost, disp_ambig} !== '0) begin errors++; $display("FAIL reset_outputs got disp=%0d min=%0d amb=%b want zeros", disp, min_cost, disp_ambig); end
        rst = 1'b0; en = 1'b1;
    endtask

    task automatic test_basic;
        logic [CW-1:0] v [4];
        v[0] = 9; v[1] = 3; v[2] = 7; v[3] = 5;
        disp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (cost_ready !== 1'b1) begin errors++; $display("FAIL basic_ready beat %0d got %b want 1", i, cost_ready); end
            checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid beat %0d got %b want 0", i, disp_valid); end
            cost_valid = 1'b1; cost = v[i];
            tick();
        end
        cost_valid = 1'b0;
        checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", disp_valid); end
        checks++; if (disp !== 2'd1) begin errors++; $display("FAIL basic_disp got %0d want 1", disp); end
        checks++; if (min_cost !== 7'd3) begin errors++; $display("FAIL basic_min got %0d want 3", min_cost); end
        checks++; if (disp_ambig !== 1'b0) begin errors++; $display("FAIL basic_ambig got %b want 0", disp_ambig); end
        tick();
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL basic_drop got %b want 0", disp_valid); end
        checks++; if (cost_ready !== 1'b1) begin errors++; $display("FAIL basic_reaccept got %b want 1", cost_ready); end
    endtask

    task automatic test_tie;
        disp_ready = 1'b0;
        stream4(4, 2, 2, 6);
        checks++; if (disp !== 2'd1) begin errors++; $display("FAIL tie_disp got %0d want 1", disp); end
        checks++; if (min_cost !== 7'd2) begin errors++; $display("FAIL tie_min got %0d want 2", min_cost); end
        checks++; if (disp_ambig !== UNIQ) begin errors++; $display("FAIL tie_ambig got %b want %b", disp_ambig, UNIQ); end
        disp_ready = 1'b1;
        tick();
    endtask

    task automatic test_backpressure;
        disp_ready = 1'b0;
        stream4(5, 6, 1, 7);
        cost_valid = 1'b1; cost = 7'd0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (disp_valid !== 1'b1 || disp !== 2'd2 || min_cost !== 7'd1 || disp_ambig !== 1'b0)
                begin errors++; $display("FAIL bp_hold cycle %0d got v=%b d=%0d m=%0d a=%b want v=1 d=2 m=1 a=0", i, disp_valid, disp, min_cost, disp_ambig); end
            checks++; if (cost_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cycle %0d got %b want 0", i, cost_ready); end
            tick();
        end
        disp_ready = 1'b1;
        tick();
        cost_valid = 1'b0;
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL bp_handshake got %b want 0", disp_valid); end
        stream4(6, 6, 1, 6);
        checks++; if (disp !== 2'd2 || min_cost !== 7'd1) begin errors++; $display("FAIL bp_next got d=%0d m=%0d want d=2 m=1", disp, min_cost); end
        tick();
    endtask

    task automatic test_mid_reset;
        disp_ready = 1'b1;
        cost_valid = 1'b1; cost = 7'd0; tick(); tick();
        cost_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        checks++; if ({disp_valid, disp, min_cost, disp_ambig} !== '0) begin errors++; $display("FAIL mrst_zero got v=%b d=%0d m=%0d a=%b want zeros", disp_valid, disp, min_cost, disp_ambig); end
        stream4(8, 1, 8, 8);
        checks++; if (disp_valid !== 1'b1 || disp !== 2'd1 || min_cost !== 7'd1) begin errors++; $display("FAIL mrst_result got v=%b d=%0d m=%0d want v=1 d=1 m=1", disp_valid, disp, min_cost); end
        tick();
        disp_ready = 1'b0;
        stream4(3, 2, 1, 0);
        checks++; if (disp_valid !== 1'b1 || disp !== 2'd3) begin errors++; $display("FAIL hrst_pre got v=%b d=%0d want v=1 d=3", disp_valid, disp); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (disp_valid !== 1'b0 || cost_ready !== 1'b1 || disp !== 2'd0) begin errors++; $display("FAIL hrst_drop got v=%b r=%b d=%0d want v=0 r=1 d=0", disp_valid, cost_ready, disp); end
    endtask

    task automatic test_stall;
        disp_ready = 1'b1;
        cost_valid = 1'b1;
        cost = 7'd7; tick();
        cost = 7'd4; tick();
        en = 1'b0; cost = 7'd0;
        for (int i = 0; i < 3; i++) tick();
        en = 1'b1;
        cost = 7'd9; tick();
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL stall_early got %b want 0", disp_valid); end
        cost = 7'd5; tick();
        cost_valid = 1'b0;
        checks++; if (disp_valid !== 1'b1 || disp !== 2'd1 || min_cost !== 7'd4) begin errors++; $display("FAIL stall_result got v=%b d=%0d m=%0d want v=1 d=1 m=4", disp_valid, disp, min_cost); end
        checks++; if (disp_ambig !== UNIQ) begin errors++; $display("FAIL stall_ambig got %b want %b", disp_ambig, UNIQ); end
        en = 1'b0; tick(); tick();
        checks++; if (disp_valid !== 1'b1 || cost_ready !== 1'b0) begin errors++; $display("FAIL stall_hold got v=%b r=%b want v=1 r=0", disp_valid, cost_ready); end
        en = 1'b1; tick();
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL stall_release got %b want 0", disp_valid); end
    endtask

    task automatic test_all_ones;
        disp_ready = 1'b0;
        stream4(7'h7f, 7'h7f, 7'h7f, 7'h7f);
        checks++; if (disp !== 2'd0) begin errors++; $display("FAIL ones_disp got %0d want 0", disp); end
        checks++; if (min_cost !== 7'h7f) begin errors++; $display("FAIL ones_min got %0d want 127", min_cost); end
        checks++; if (disp_ambig !== UNIQ) begin errors++; $display("FAIL ones_ambig got %b want %b", disp_ambig, UNIQ); end
        disp_ready = 1'b1; tick();
        checks++; if (disp_valid !== 1'b0 || cost_ready !== 1'b1) begin errors++; $display("FAIL ones_done got v=%b r=%b want v=0 r=1", disp_valid, cost_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_backpressure();
        test_mid_reset();
        test_stall();
        test_all_ones();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
